wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back stage of the 5-stage MIPS pipeline; sits directly downstream of the MEM stage.
//  Latches the MEM outputs into the MEM/WB register and selects load data or ALU result.
//  Drives the register-file write port and a one-cycle bypass of the last committed write.
//  Carries the debug instruction tag to the WB slot and counts retired instructions and loads.
// PARAMETERS
//  DW      32  datapath width (mdata, aluR, wdata)
//  RW      5   register-index width
//  CNT_W   32  width of the retire/load counters
// PORTS
//  clk             in   1     pipeline clock; all state updates on posedge
//  rst             in   1     synchronous, active-high reset
//  stall           in   1     hold the MEM/WB register (hazard unit)
//  flush           in   1     load a bubble into the MEM/WB register
//  mem_wreg        in   1     MEM-slot instruction writes a register
//  mem_m2reg       in   1     MEM-slot result comes from data memory
//  mem_mdata       in   DW    data-memory read data
//  mem_aluR        in   DW    ALU result forwarded through MEM
//  mem_destR       in   RW    destination register index
//  MEM_ins_type    in   4     debug tag: instruction type in MEM
//  MEM_ins_number  in   4     debug tag: instruction number in MEM
//  wb_wreg         out  1     register-file write enable
//  wb_destR        out  RW    register-file write index
//  wb_wdata        out  DW    register-file write data
//  wb_last_valid   out  1     bypass entry valid
//  wb_last_destR   out  RW    destination of the previous cycle's committed write
//  wb_last_data    out  DW    data of the previous cycle's committed write
//  WB_ins_type     out  4     debug tag in WB
//  WB_ins_number   out  4     debug tag in WB
//  retired_cnt     out  CNT_W count of non-bubble instructions leaving WB
//  load_cnt        out  CNT_W count of retired loads (m2reg=1)
// BEHAVIOUR
//  - Priority each posedge: rst > flush > stall > normal load.
//  - Reset: MEM/WB register cleared (wreg=0, m2reg=0, data/dest=0, type/number=0); outputs match:
//    wb_wreg=0, wb_destR=0, wb_wdata=0, wb_last_valid=0, wb_last_destR=0, wb_last_data=0,
//    WB_ins_type=0, WB_ins_number=0, retired_cnt=0, load_cnt=0.
//  - Normal: every MEM/WB field captures its MEM input. Latency is 1 cycle MEM->WB.
//  - wb_wdata = m2reg ? mdata_q : aluR_q, combinational from the register.
//  - wb_wreg = wreg_q & (destR_q != 0). Writes to r0 are suppressed and do not update the bypass.
//  - flush: register loads a bubble (all zero, type=0); flush during stall still inserts the bubble.
//  - stall: register holds; counters and bypass do not advance.
//    The held instruction is counted only once, when it leaves WB.
//  - Bypass: on each non-stalled posedge, wb_last_* captures {wb_wreg, wb_destR, wb_wdata};
//    wb_last_valid = captured wb_wreg.
//  - Counters: on each non-stalled posedge with WB slot non-bubble (WB_ins_type!=0),
//    retired_cnt+=1; if m2reg_q also set, load_cnt+=1. Wrap modulo 2^CNT_W, no saturation.
//  - Reset mid-stall or mid-flush: reset wins; no partial counter update.
// STRUCTURE
//  - Shared package/header: ins-type codes (incl. BUBBLE=0), DW/RW defaults.
//  - Sub-module reg_mem_wb: MEM/WB pipeline register with stall/flush.
//    Mux, r0 gating, bypass and counters live in wb_stage.
// TESTING
//  1 Reset: rst=1 for 2 cycles with random inputs -> all outputs 0.
//  2 ALU op: wreg=1, m2reg=0, aluR=0x12345678, destR=8 -> next cycle wb_wreg=1, destR=8,
//    wdata=0x12345678; following cycle wb_last_destR=8, last_data=0x12345678.
//  3 Load: m2reg=1, mdata=0xDEADBEEF, aluR=0x40, type=LW -> wdata=0xDEADBEEF; load_cnt 0->1.
//  4 r0 write: wreg=1, destR=0 -> wb_wreg=0, wb_last_valid=0; retired_cnt still increments.
//  5 Stall 3 cycles with one instruction in WB -> outputs held, retired_cnt +1 total, not +4.
//  6 flush & stall together -> bubble: wb_wreg=0, WB_ins_type=0; counters unchanged next cycle.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: default widths and the
// debug instruction-type codes carried alongside each pipeline slot.
package wb_stage_pkg;

    localparam int DEF_DW     = 32;
    localparam int DEF_RW     = 5;
    localparam int DEF_CNT_W  = 32;
    localparam int INS_TYPE_W = 4;
    localparam int INS_NUM_W  = 4;

    // A slot tagged INS_BUBBLE carries no instruction and is never counted.
    typedef enum logic [INS_TYPE_W-1:0] {
        INS_BUBBLE = 4'd0,
        INS_ALU    = 4'd1,
        INS_LW     = 4'd2,
        INS_SW     = 4'd3,
        INS_BRANCH = 4'd4,
        INS_JUMP   = 4'd5
    } ins_type_e;

    function automatic logic is_bubble(input logic [INS_TYPE_W-1:0] ins_type);
        return ins_type == INS_BUBBLE;
    endfunction

endpackage

// File: rtl/reg_mem_wb.sv
// MEM/WB pipeline register.
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   stall_i           hold current contents
//   flush_i           load a bubble (wins over stall)
//   *_i               MEM-slot fields captured on a normal cycle
//   *_o               registered WB-slot fields
module reg_mem_wb
    import wb_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  wreg_i,
    input  logic                  m2reg_i,
    input  logic [DW-1:0]         mdata_i,
    input  logic [DW-1:0]         aluR_i,
    input  logic [RW-1:0]         destR_i,
    input  logic [INS_TYPE_W-1:0] ins_type_i,
    input  logic [INS_NUM_W-1:0]  ins_number_i,
    output logic                  wreg_o,
    output logic                  m2reg_o,
    output logic [DW-1:0]         mdata_o,
    output logic [DW-1:0]         aluR_o,
    output logic [RW-1:0]         destR_o,
    output logic [INS_TYPE_W-1:0] ins_type_o,
    output logic [INS_NUM_W-1:0]  ins_number_o
);

    always_ff @(posedge clk) begin
        // A bubble is the same all-zero image as reset, so both share a branch.
        if (rst || flush_i) begin
            wreg_o       <= 1'b0;
            m2reg_o      <= 1'b0;
            mdata_o      <= '0;
            aluR_o       <= '0;
            destR_o      <= '0;
            ins_type_o   <= INS_BUBBLE;
            ins_number_o <= '0;
        end else if (!stall_i) begin
            wreg_o       <= wreg_i;
            m2reg_o      <= m2reg_i;
            mdata_o      <= mdata_i;
            aluR_o       <= aluR_i;
            destR_o      <= destR_i;
            ins_type_o   <= ins_type_i;
            ins_number_o <= ins_number_i;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load/ALU result select, r0 write
// suppression, one-entry bypass of the last committed write, and
// retired/load instruction counters.
// Ports:
//   clk, rst, stall, flush             clock, sync reset, hazard controls
//   mem_*, MEM_ins_*                   MEM-slot inputs
//   wb_wreg, wb_destR, wb_wdata        register-file write port
//   wb_last_valid/destR/data           bypass of previous cycle's write
//   WB_ins_type, WB_ins_number         debug tag in WB
//   retired_cnt, load_cnt              free-running wrap-around counters
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int RW    = DEF_RW,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_wreg,
    input  logic                  mem_m2reg,
    input  logic [DW-1:0]         mem_mdata,
    input  logic [DW-1:0]         mem_aluR,
    input  logic [RW-1:0]         mem_destR,
    input  logic [INS_TYPE_W-1:0] MEM_ins_type,
    input  logic [INS_NUM_W-1:0]  MEM_ins_number,
    output logic                  wb_wreg,
    output logic [RW-1:0]         wb_destR,
    output logic [DW-1:0]         wb_wdata,
    output logic                  wb_last_valid,
    output logic [RW-1:0]         wb_last_destR,
    output logic [DW-1:0]         wb_last_data,
    output logic [INS_TYPE_W-1:0] WB_ins_type,
    output logic [INS_NUM_W-1:0]  WB_ins_number,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      load_cnt
);

    logic          wreg_q;
    logic          m2reg_q;
    logic [DW-1:0] mdata_q;
    logic [DW-1:0] aluR_q;

    logic             last_valid_q, last_valid_d;
    logic [RW-1:0]    last_destR_q, last_destR_d;
    logic [DW-1:0]    last_data_q,  last_data_d;
    logic [CNT_W-1:0] retired_q,    retired_d;
    logic [CNT_W-1:0] load_q,       load_d;

    reg_mem_wb #(.DW(DW), .RW(RW)) u_reg_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .wreg_i       (mem_wreg),
        .m2reg_i      (mem_m2reg),
        .mdata_i      (mem_mdata),
        .aluR_i       (mem_aluR),
        .destR_i      (mem_destR),
        .ins_type_i   (MEM_ins_type),
        .ins_number_i (MEM_ins_number),
        .wreg_o       (wreg_q),
        .m2reg_o      (m2reg_q),
        .mdata_o      (mdata_q),
        .aluR_o       (aluR_q),
        .destR_o      (wb_destR),
        .ins_type_o   (WB_ins_type),
        .ins_number_o (WB_ins_number)
    );

    // r0 is hard-wired zero, so a write to it must never reach the file.
    assign wb_wreg  = wreg_q & (wb_destR != '0);
    assign wb_wdata = m2reg_q ? mdata_q : aluR_q;

    // Bypass and counters only advance on edges where the slot actually
    // moves; a stall (with or without flush) freezes them so a held
    // instruction is counted exactly once.
    always_comb begin
        last_valid_d = last_valid_q;
        last_destR_d = last_destR_q;
        last_data_d  = last_data_q;
        retired_d    = retired_q;
        load_d       = load_q;
        if (!stall) begin
            last_valid_d = wb_wreg;
            last_destR_d = wb_destR;
            last_data_d  = wb_wdata;
            if (!is_bubble(WB_ins_type)) begin
                retired_d = retired_q + CNT_W'(1);
                if (m2reg_q) begin
                    load_d = load_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid_q <= 1'b0;
            last_destR_q <= '0;
            last_data_q  <= '0;
            retired_q    <= '0;
            load_q       <= '0;
        end else begin
            last_valid_q <= last_valid_d;
            last_destR_q <= last_destR_d;
            last_data_q  <= last_data_d;
            retired_q    <= retired_d;
            load_q       <= load_d;
        end
    end

    assign wb_last_valid = last_valid_q;
    assign wb_last_destR = last_destR_q;
    assign wb_last_data  = last_data_q;
    assign retired_cnt   = retired_q;
    assign load_cnt      = load_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_wreg, mem_m2reg;
    logic [31:0] mem_mdata, mem_aluR;
    logic [4:0]  mem_destR;
    logic [3:0]  MEM_ins_type, MEM_ins_number;
    logic        wb_wreg, wb_last_valid;
    logic [4:0]  wb_destR, wb_last_destR;
    logic [31:0] wb_wdata, wb_last_data;
    logic [3:0]  WB_ins_type, WB_ins_number;
    logic [31:0] retired_cnt, load_cnt;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_mdata(mem_mdata),
        .mem_aluR(mem_aluR), .mem_destR(mem_destR),
        .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number),
        .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_wdata(wb_wdata),
        .wb_last_valid(wb_last_valid), .wb_last_destR(wb_last_destR),
        .wb_last_data(wb_last_data), .WB_ins_type(WB_ins_type),
        .WB_ins_number(WB_ins_number), .retired_cnt(retired_cnt),
        .load_cnt(load_cnt)
    );

    always #5 clk = ~clk;

    // Inputs plus hand-computed expected write enable / write data.
    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mdata;
        logic [31:0] aluR;
        logic [4:0]  dest;
        logic [3:0]  typ;
        logic [3:0]  num;
        logic        e_wreg;
        logic [31:0] e_wdata;
    } vec_t;

    int tests = 0;
    int fails = 0;

    vec_t vecs[7];
    vec_t prev, zero_v, vx, vy, vz;
    int unsigned exp_ret, exp_load, ret_before;
    logic        exp_last_valid;
    logic [4:0]  exp_last_dest;
    logic [31:0] exp_last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        mem_wreg       = v.wreg;
        mem_m2reg      = v.m2reg;
        mem_mdata      = v.mdata;
        mem_aluR       = v.aluR;
        mem_destR      = v.dest;
        MEM_ins_type   = v.typ;
        MEM_ins_number = v.num;
    endtask

    // Apply one vector on a normal cycle and check WB, bypass and counters.
    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        step();
        if (prev.typ != 4'd0) begin
            exp_ret++;
            if (prev.m2reg) exp_load++;
        end
        exp_last_valid = prev.e_wreg;
        exp_last_dest  = prev.dest;
        exp_last_data  = prev.e_wdata;
        chk({tag, " wb_wreg"},       32'(wb_wreg),       32'(v.e_wreg));
        chk({tag, " wb_destR"},      32'(wb_destR),      32'(v.dest));
        chk({tag, " wb_wdata"},      wb_wdata,           v.e_wdata);
        chk({tag, " WB_ins_type"},   32'(WB_ins_type),   32'(v.typ));
        chk({tag, " WB_ins_number"}, 32'(WB_ins_number), 32'(v.num));
        chk({tag, " last_valid"},    32'(wb_last_valid), 32'(exp_last_valid));
        chk({tag, " last_destR"},    32'(wb_last_destR), 32'(exp_last_dest));
        chk({tag, " last_data"},     wb_last_data,       exp_last_data);
        chk({tag, " retired_cnt"},   retired_cnt,        exp_ret);
        chk({tag, " load_cnt"},      load_cnt,           exp_load);
        prev = v;
    endtask

    initial begin
        //          wreg m2r mdata         aluR          dst typ   num   e_wreg e_wdata
        vecs[0] = '{1'b1, 1'b0, 32'hAAAA0000, 32'h12345678, 5'd8,  4'd1, 4'd1, 1'b1, 32'h12345678};
        vecs[1] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h00000040, 5'd9,  4'd2, 4'd2, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h11111111, 32'h00000055, 5'd0,  4'd1, 4'd3, 1'b0, 32'h00000055};
        vecs[3] = '{1'b0, 1'b0, 32'h22222222, 32'h00000080, 5'd3,  4'd3, 4'd4, 1'b0, 32'h00000080};
        vecs[4] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'd0,  4'd0, 4'd0, 1'b0, 32'h00000000};
        vecs[5] = '{1'b1, 1'b0, 32'h33333333, 32'hFFFFFFFF, 5'd31, 4'd1, 4'd15, 1'b1, 32'hFFFFFFFF};
        vecs[6] = '{1'b1, 1'b1, 32'h00000001, 32'h00000099, 5'd1,  4'd2, 4'd6, 1'b1, 32'h00000001};
        zero_v  = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 4'd0, 1'b0, 32'h0};
        vx      = '{1'b1, 1'b0, 32'h0, 32'h00000777, 5'd5, 4'd1, 4'd7, 1'b1, 32'h00000777};
        vy      = '{1'b1, 1'b1, 32'hBBBBBBBB, 32'h00000123, 5'd12, 4'd2, 4'd8, 1'b1, 32'hBBBBBBBB};
        vz      = '{1'b1, 1'b1, 32'hCAFEF00D, 32'h00000010, 5'd10, 4'd2, 4'd9, 1'b1, 32'hCAFEF00D};

        // Reset with random inputs for two cycles.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stall = 1'($urandom); flush = 1'($urandom);
            mem_wreg = 1'($urandom); mem_m2reg = 1'($urandom);
            mem_mdata = $urandom; mem_aluR = $urandom;
            mem_destR = 5'($urandom); MEM_ins_type = 4'($urandom);
            MEM_ins_number = 4'($urandom);
            step();
        end
        chk("rst wb_wreg",       32'(wb_wreg),       32'd0);
        chk("rst wb_destR",      32'(wb_destR),      32'd0);
        chk("rst wb_wdata",      wb_wdata,           32'd0);
        chk("rst last_valid",    32'(wb_last_valid), 32'd0);
        chk("rst last_destR",    32'(wb_last_destR), 32'd0);
        chk("rst last_data",     wb_last_data,       32'd0);
        chk("rst WB_ins_type",   32'(WB_ins_type),   32'd0);
        chk("rst WB_ins_number", 32'(WB_ins_number), 32'd0);
        chk("rst retired_cnt",   retired_cnt,        32'd0);
        chk("rst load_cnt",      load_cnt,           32'd0);

        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(zero_v);
        prev = zero_v; exp_ret = 0; exp_load = 0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stall three cycles with vx in WB: everything holds.
        run_vec(vx, "pre_stall");
        ret_before = exp_ret;
        stall = 1'b1;
        drive(vy);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall wb_destR",    32'(wb_destR),      32'd5);
            chk("stall wb_wdata",    wb_wdata,           32'h00000777);
            chk("stall WB_ins_num",  32'(WB_ins_number), 32'd7);
            chk("stall retired_cnt", retired_cnt,        exp_ret);
            chk("stall last_destR",  32'(wb_last_destR), 32'(exp_last_dest));
            chk("stall last_data",   wb_last_data,       exp_last_data);
        end
        stall = 1'b0;
        run_vec(zero_v, "post_stall");
        chk("stall retired +1", retired_cnt, ret_before + 1);

        // Flush together with stall inserts a bubble; nothing counted.
        run_vec(vz, "pre_flush");
        flush = 1'b1; stall = 1'b1;
        drive(vy);
        step();
        chk("flush wb_wreg",     32'(wb_wreg),       32'd0);
        chk("flush WB_ins_type", 32'(WB_ins_type),   32'd0);
        chk("flush wb_wdata",    wb_wdata,           32'd0);
        chk("flush retired_cnt", retired_cnt,        exp_ret);
        chk("flush load_cnt",    load_cnt,           exp_load);
        chk("flush last_destR",  32'(wb_last_destR), 32'(exp_last_dest));
        flush = 1'b0; stall = 1'b0;
        prev = zero_v;
        run_vec(zero_v, "post_flush");

        // Reset asserted together with stall and flush wins outright.
        run_vec(vy, "pre_rst");
        run_vec(vx, "pre_rst2");
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        step();
        chk("rst2 retired_cnt", retired_cnt,        32'd0);
        chk("rst2 load_cnt",    load_cnt,           32'd0);
        chk("rst2 wb_wreg",     32'(wb_wreg),       32'd0);
        chk("rst2 WB_ins_type", 32'(WB_ins_type),   32'd0);
        chk("rst2 last_valid",  32'(wb_last_valid), 32'd0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
